// File: rtl/dlk_region_tracker.sv
// dlk_region_tracker: per-base high-water-mark table for data-leak detection.
// Stores grow a region's high-water mark; loads past it raise a registered
// over-read flag, one cycle after the load.
// Optional build macro DLK_STICKY_EN: overflow_o latches until flush/reset and
// overflow_addr_o keeps the first offending address.
module dlk_region_tracker #(
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 32,
  parameter int MAX_SPAN = 256
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       st_valid_i,
  input  logic [ADDR_W-1:0]          st_base_i,
  input  logic [ADDR_W-1:0]          st_addr_i,
  input  logic                       ld_valid_i,
  input  logic [ADDR_W-1:0]          ld_base_i,
  input  logic [ADDR_W-1:0]          ld_addr_i,
  output logic                       overflow_o,
  output logic [ADDR_W-1:0]          overflow_addr_o,
  output logic [$clog2(DEPTH):0]     occupancy_o,
  output logic                       full_o,
  output logic [15:0]                overflow_cnt_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] L_SPAN  = ADDR_W'(MAX_SPAN);
  localparam logic [PW:0]       L_DEPTH = (PW+1)'(DEPTH);

  logic [DEPTH-1:0]  r_valid;
  logic [ADDR_W-1:0] r_base [DEPTH];
  logic [ADDR_W-1:0] r_hwm  [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW:0]       r_occ;
  logic              r_ovf;
  logic [ADDR_W-1:0] r_ovf_addr;
  logic [15:0]       r_cnt;

  logic [ADDR_W-1:0] w_offset;
  logic              w_st_acc;
  logic              w_st_hit;
  logic [PW-1:0]     w_st_idx;
  logic              w_ld_hit;
  logic [ADDR_W-1:0] w_ld_hwm;
  logic              w_fwd;
  logic [ADDR_W-1:0] w_eff_hwm;
  logic              w_viol;

  // Associative lookup for both ports, store acceptance and the load check with same-cycle forwarding
  always_comb begin
    w_offset  = st_addr_i - st_base_i;
    w_st_acc  = st_valid_i && !flush_i && (st_addr_i >= st_base_i) && (w_offset <= L_SPAN);
    w_st_hit  = 1'b0;
    w_st_idx  = '0;
    w_ld_hit  = 1'b0;
    w_ld_hwm  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_base[i] == st_base_i)) begin
        w_st_hit = 1'b1;
        w_st_idx = PW'(i);
      end
      if (r_valid[i] && (r_base[i] == ld_base_i)) begin
        w_ld_hit = 1'b1;
        w_ld_hwm = r_hwm[i];
      end
    end
    w_fwd     = w_st_acc && (st_base_i == ld_base_i);
    w_eff_hwm = w_ld_hwm;
    if (w_fwd && (!w_ld_hit || (st_addr_i > w_ld_hwm))) begin
      w_eff_hwm = st_addr_i;
    end
    w_viol = ld_valid_i && (w_ld_hit || w_fwd) &&
             (ld_addr_i >= ld_base_i) && (ld_addr_i > w_eff_hwm);
  end

  // Region table: flush clears, store hit raises the mark, store miss allocates FIFO-style
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid  <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_base[i] <= '0;
        r_hwm[i]  <= '0;
      end
    end else if (flush_i) begin
      r_valid  <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
    end else if (w_st_acc) begin
      if (w_st_hit) begin
        if (st_addr_i > r_hwm[w_st_idx]) begin
          r_hwm[w_st_idx] <= st_addr_i;
        end
      end else begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_base[r_wr_ptr]  <= st_base_i;
        r_hwm[r_wr_ptr]   <= st_addr_i;
        r_wr_ptr          <= r_wr_ptr + 1'b1;
        if (r_occ != L_DEPTH) begin
          r_occ <= r_occ + 1'b1;
        end
      end
    end
  end

  // Registered detection result, captured address and saturating detection counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ovf      <= 1'b0;
      r_ovf_addr <= '0;
      r_cnt      <= '0;
    end else begin
`ifdef DLK_STICKY_EN
      r_ovf <= (r_ovf & ~flush_i) | w_viol;
      if (w_viol && (!r_ovf || flush_i)) begin
        r_ovf_addr <= ld_addr_i;
      end
`else
      r_ovf <= w_viol;
      if (w_viol) begin
        r_ovf_addr <= ld_addr_i;
      end
`endif
      if (w_viol && (r_cnt != 16'hFFFF)) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign overflow_o      = r_ovf;
  assign overflow_addr_o = r_ovf_addr;
  assign occupancy_o     = r_occ;
  assign full_o          = (r_occ == L_DEPTH);
  assign overflow_cnt_o  = r_cnt;

endmodule

// File: tb/tb_dlk_region_tracker.sv
// tb_dlk_region_tracker: directed-vector bench for dlk_region_tracker.
// Each task drives one scenario and compares outputs against hand-computed values.
module tb_dlk_region_tracker;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        st_valid_i = 1'b0;
  logic [31:0] st_base_i = '0;
  logic [31:0] st_addr_i = '0;
  logic        ld_valid_i = 1'b0;
  logic [31:0] ld_base_i = '0;
  logic [31:0] ld_addr_i = '0;
  logic        overflow_o;
  logic [31:0] overflow_addr_o;
  logic [3:0]  occupancy_o;
  logic        full_o;
  logic [15:0] overflow_cnt_o;

  int total = 0;
  int bad = 0;
  logic [15:0] expCnt = 16'd0;

  dlk_region_tracker #(.DEPTH(8), .ADDR_W(32), .MAX_SPAN(256)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .st_valid_i(st_valid_i), .st_base_i(st_base_i), .st_addr_i(st_addr_i),
    .ld_valid_i(ld_valid_i), .ld_base_i(ld_base_i), .ld_addr_i(ld_addr_i),
    .overflow_o(overflow_o), .overflow_addr_o(overflow_addr_o),
    .occupancy_o(occupancy_o), .full_o(full_o), .overflow_cnt_o(overflow_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // One clock of stimulus; returns 1ns after the edge so registered results are visible
  task automatic step(input logic sv, input logic [31:0] sb, input logic [31:0] sa,
                      input logic lv, input logic [31:0] lb, input logic [31:0] la,
                      input logic fl);
    st_valid_i = sv; st_base_i = sb; st_addr_i = sa;
    ld_valid_i = lv; ld_base_i = lb; ld_addr_i = la;
    flush_i = fl;
    @(posedge clk_i);
    #1;
    st_valid_i = 1'b0; ld_valid_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++; if (overflow_o !== 1'b0) begin $display("[TB] FAIL reset_ovf got=%0b exp=0", overflow_o); bad++; end
    total++; if (overflow_addr_o !== 32'h0) begin $display("[TB] FAIL reset_addr got=%h exp=0", overflow_addr_o); bad++; end
    total++; if (occupancy_o !== 4'd0) begin $display("[TB] FAIL reset_occ got=%0d exp=0", occupancy_o); bad++; end
    total++; if (full_o !== 1'b0) begin $display("[TB] FAIL reset_full got=%0b exp=0", full_o); bad++; end
    total++; if (overflow_cnt_o !== 16'd0) begin $display("[TB] FAIL reset_cnt got=%0d exp=0", overflow_cnt_o); bad++; end
    rst_ni = 1'b1;
  endtask

  task automatic test_store_load();
    for (int k = 0; k < 8; k++) step(1, 32'h1000, 32'h1000 + k, 0, 0, 0, 0);
    total++; if (occupancy_o !== 4'd1) begin $display("[TB] FAIL sl_occ got=%0d exp=1", occupancy_o); bad++; end
    step(0, 0, 0, 1, 32'h1000, 32'h1005, 0);
    total++; if (overflow_o !== 1'b0) begin $display("[TB] FAIL sl_inrange got=%0b exp=0", overflow_o); bad++; end
    step(0, 0, 0, 1, 32'h1000, 32'h1008, 0);
    expCnt++;
    total++; if (overflow_o !== 1'b1) begin $display("[TB] FAIL sl_over got=%0b exp=1", overflow_o); bad++; end
    total++; if (overflow_addr_o !== 32'h1008) begin $display("[TB] FAIL sl_addr got=%h exp=1008", overflow_addr_o); bad++; end
    total++; if (overflow_cnt_o !== expCnt) begin $display("[TB] FAIL sl_cnt got=%0d exp=%0d", overflow_cnt_o, expCnt); bad++; end
    step(0, 0, 0, 0, 0, 0, 0);
`ifdef DLK_STICKY_EN
    total++; if (overflow_o !== 1'b1) begin $display("[TB] FAIL sl_hold got=%0b exp=1", overflow_o); bad++; end
`else
    total++; if (overflow_o !== 1'b0) begin $display("[TB] FAIL sl_pulse got=%0b exp=0", overflow_o); bad++; end
`endif
    step(0, 0, 0, 0, 0, 0, 1);
    total++; if (overflow_o !== 1'b0) begin $display("[TB] FAIL sl_flush got=%0b exp=0", overflow_o); bad++; end
  endtask

  task automatic test_forward();
    step(1, 32'h2000, 32'h2000, 1, 32'h2000, 32'h2000, 0);
    total++; if (overflow_o !== 1'b0) begin $display("[TB] FAIL fw_new got=%0b exp=0", overflow_o); bad++; end
    step(1, 32'h2000, 32'h2002, 1, 32'h2000, 32'h2002, 0);
    total++; if (overflow_o !== 1'b0) begin $display("[TB] FAIL fw_grow got=%0b exp=0", overflow_o); bad++; end
    step(1, 32'h2000, 32'h2001, 1, 32'h2000, 32'h2002, 0);
    total++; if (overflow_o !== 1'b0) begin $display("[TB] FAIL fw_lower got=%0b exp=0", overflow_o); bad++; end
    step(0, 0, 0, 1, 32'h2000, 32'h2002, 0);
    total++; if (overflow_o !== 1'b0) begin $display("[TB] FAIL fw_keepmax got=%0b exp=0", overflow_o); bad++; end
    step(0, 0, 0, 1, 32'h2000, 32'h2003, 0);
    expCnt++;
    total++; if (overflow_o !== 1'b1) begin $display("[TB] FAIL fw_over got=%0b exp=1", overflow_o); bad++; end
    total++; if (overflow_addr_o !== 32'h2003) begin $display("[TB] FAIL fw_addr got=%h exp=2003", overflow_addr_o); bad++; end
    step(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_evict();
    for (int k = 0; k < 8; k++) step(1, 32'h100 * k, 32'h100 * k, 0, 0, 0, 0);
    total++; if (occupancy_o !== 4'd8) begin $display("[TB] FAIL ev_occ8 got=%0d exp=8", occupancy_o); bad++; end
    total++; if (full_o !== 1'b1) begin $display("[TB] FAIL ev_full got=%0b exp=1", full_o); bad++; end
    step(1, 32'h800, 32'h800, 0, 0, 0, 0);
    total++; if (occupancy_o !== 4'd8) begin $display("[TB] FAIL ev_occ9 got=%0d exp=8", occupancy_o); bad++; end
    total++; if (full_o !== 1'b1) begin $display("[TB] FAIL ev_full9 got=%0b exp=1", full_o); bad++; end
    step(0, 0, 0, 1, 32'h0, 32'h10, 0);
    total++; if (overflow_o !== 1'b0) begin $display("[TB] FAIL ev_evicted got=%0b exp=0", overflow_o); bad++; end
    step(0, 0, 0, 1, 32'h800, 32'h800, 0);
    total++; if (overflow_o !== 1'b0) begin $display("[TB] FAIL ev_newest got=%0b exp=0", overflow_o); bad++; end
    step(0, 0, 0, 1, 32'h100, 32'h110, 0);
    expCnt++;
    total++; if (overflow_o !== 1'b1) begin $display("[TB] FAIL ev_kept got=%0b exp=1", overflow_o); bad++; end
    total++; if (overflow_cnt_o !== expCnt) begin $display("[TB] FAIL ev_cnt got=%0d exp=%0d", overflow_cnt_o, expCnt); bad++; end
    step(0, 0, 0, 0, 0, 0, 1);
    total++; if (occupancy_o !== 4'd0) begin $display("[TB] FAIL ev_flush got=%0d exp=0", occupancy_o); bad++; end
    total++; if (full_o !== 1'b0) begin $display("[TB] FAIL ev_flushfull got=%0b exp=0", full_o); bad++; end
  endtask

  task automatic test_ignore();
    step(1, 32'h3000, 32'h3101, 0, 0, 0, 0);
    total++; if (occupancy_o !== 4'd0) begin $display("[TB] FAIL ig_span got=%0d exp=0", occupancy_o); bad++; end
    step(1, 32'h3000, 32'h2FFF, 0, 0, 0, 0);
    total++; if (occupancy_o !== 4'd0) begin $display("[TB] FAIL ig_below got=%0d exp=0", occupancy_o); bad++; end
    step(1, 32'h3000, 32'h3100, 0, 0, 0, 0);
    total++; if (occupancy_o !== 4'd1) begin $display("[TB] FAIL ig_edge got=%0d exp=1", occupancy_o); bad++; end
    step(0, 0, 0, 1, 32'h3000, 32'h2FFF, 0);
    total++; if (overflow_o !== 1'b0) begin $display("[TB] FAIL ig_ldbelow got=%0b exp=0", overflow_o); bad++; end
    step(0, 0, 0, 1, 32'h3000, 32'h3100, 0);
    total++; if (overflow_o !== 1'b0) begin $display("[TB] FAIL ig_ldedge got=%0b exp=0", overflow_o); bad++; end
    step(0, 0, 0, 1, 32'h3000, 32'h3101, 0);
    expCnt++;
    total++; if (overflow_addr_o !== 32'h3101) begin $display("[TB] FAIL ig_addr got=%h exp=3101", overflow_addr_o); bad++; end
    step(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_flush();
    step(1, 32'h4000, 32'h4000, 0, 0, 0, 0);
    step(1, 32'h4100, 32'h4100, 0, 0, 0, 0);
    step(1, 32'h4200, 32'h4200, 0, 0, 0, 0);
    total++; if (occupancy_o !== 4'd3) begin $display("[TB] FAIL fl_fill got=%0d exp=3", occupancy_o); bad++; end
    step(1, 32'h4300, 32'h4300, 0, 0, 0, 1);
    total++; if (occupancy_o !== 4'd0) begin $display("[TB] FAIL fl_occ got=%0d exp=0", occupancy_o); bad++; end
    step(0, 0, 0, 1, 32'h4000, 32'h4005, 0);
    total++; if (overflow_o !== 1'b0) begin $display("[TB] FAIL fl_old got=%0b exp=0", overflow_o); bad++; end
    step(0, 0, 0, 1, 32'h4300, 32'h4301, 0);
    total++; if (overflow_o !== 1'b0) begin $display("[TB] FAIL fl_dropped got=%0b exp=0", overflow_o); bad++; end
    total++; if (overflow_cnt_o !== expCnt) begin $display("[TB] FAIL fl_cntkeep got=%0d exp=%0d", overflow_cnt_o, expCnt); bad++; end
    step(1, 32'h4000, 32'h4000, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h4000, 32'h4001, 1);
    expCnt++;
    total++; if (overflow_o !== 1'b1) begin $display("[TB] FAIL fl_preflush got=%0b exp=1", overflow_o); bad++; end
    total++; if (overflow_addr_o !== 32'h4001) begin $display("[TB] FAIL fl_addr got=%h exp=4001", overflow_addr_o); bad++; end
    total++; if (occupancy_o !== 4'd0) begin $display("[TB] FAIL fl_occ2 got=%0d exp=0", occupancy_o); bad++; end
    step(0, 0, 0, 0, 0, 0, 1);
    total++; if (overflow_o !== 1'b0) begin $display("[TB] FAIL fl_clear got=%0b exp=0", overflow_o); bad++; end
  endtask

  task automatic test_back_to_back();
    step(1, 32'h5000, 32'h5000, 0, 0, 0, 0);
    step(1, 32'h6000, 32'h6000, 1, 32'h5000, 32'h5001, 0);
    expCnt++;
    total++; if (overflow_o !== 1'b1) begin $display("[TB] FAIL bb_first got=%0b exp=1", overflow_o); bad++; end
    total++; if (occupancy_o !== 4'd2) begin $display("[TB] FAIL bb_occ got=%0d exp=2", occupancy_o); bad++; end
    step(0, 0, 0, 1, 32'h6000, 32'h6001, 0);
    expCnt++;
    total++; if (overflow_o !== 1'b1) begin $display("[TB] FAIL bb_second got=%0b exp=1", overflow_o); bad++; end
    total++; if (overflow_cnt_o !== expCnt) begin $display("[TB] FAIL bb_cnt got=%0d exp=%0d", overflow_cnt_o, expCnt); bad++; end
`ifdef DLK_STICKY_EN
    total++; if (overflow_addr_o !== 32'h5001) begin $display("[TB] FAIL bb_addr got=%h exp=5001", overflow_addr_o); bad++; end
`else
    total++; if (overflow_addr_o !== 32'h6001) begin $display("[TB] FAIL bb_addr got=%h exp=6001", overflow_addr_o); bad++; end
`endif
    step(0, 0, 0, 0, 0, 0, 1);
    total++; if (overflow_o !== 1'b0) begin $display("[TB] FAIL bb_flush got=%0b exp=0", overflow_o); bad++; end
    total++; if (overflow_cnt_o !== expCnt) begin $display("[TB] FAIL bb_cntkeep got=%0d exp=%0d", overflow_cnt_o, expCnt); bad++; end
  endtask

  task automatic test_reset_mid();
    step(1, 32'h7000, 32'h7000, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h7000, 32'h7001, 0);
    expCnt++;
    total++; if (overflow_o !== 1'b1) begin $display("[TB] FAIL rm_pre got=%0b exp=1", overflow_o); bad++; end
    rst_ni = 1'b0;
    #2;
    expCnt = 16'd0;
    total++; if (overflow_o !== 1'b0) begin $display("[TB] FAIL rm_ovf got=%0b exp=0", overflow_o); bad++; end
    total++; if (overflow_addr_o !== 32'h0) begin $display("[TB] FAIL rm_addr got=%h exp=0", overflow_addr_o); bad++; end
    total++; if (overflow_cnt_o !== expCnt) begin $display("[TB] FAIL rm_cnt got=%0d exp=0", overflow_cnt_o); bad++; end
    total++; if (occupancy_o !== 4'd0) begin $display("[TB] FAIL rm_occ got=%0d exp=0", occupancy_o); bad++; end
    #2;
    rst_ni = 1'b1;
    step(0, 0, 0, 1, 32'h7000, 32'h7001, 0);
    total++; if (overflow_o !== 1'b0) begin $display("[TB] FAIL rm_after got=%0b exp=0", overflow_o); bad++; end
  endtask

  initial begin
    $display("[TB] starting dlk_region_tracker bench");
    test_reset();
    test_store_load();
    test_forward();
    test_evict();
    test_ignore();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dlk_region_tracker.md
Name: dlk_region_tracker

Overview:
- Tracks which byte region each pointer base has written, so over-reads can be caught (data-leak detection).
- Sits directly downstream of the branch/ALU stage.
- Consumes per-instruction write pulses and base/effective addresses from that stage.
- Returns a registered over-read flag, which the stage uses to force a crash target.
- Each entry holds one base address and the highest byte address stored through that base (the high-water mark).

Parameters:
- DEPTH, 8, number of tracked regions; power of two, ≥2.
- ADDR_W, 32, address width.
- MAX_SPAN, 256, largest legal offset (st_addr − st_base) accepted into a region.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  invalidate all entries
- st_valid_i  in  1  byte store issued
- st_base_i  in  ADDR_W  store base register value (operand_a)
- st_addr_i  in  ADDR_W  store effective address
- ld_valid_i  in  1  load (LW/LH/LB) issued
- ld_base_i  in  ADDR_W  load base register value
- ld_addr_i  in  ADDR_W  load effective address
- overflow_o  out  1  over-read detected (registered)
- overflow_addr_o  out  ADDR_W  ld_addr of the offending load
- occupancy_o  out  $clog2(DEPTH)+1  valid entry count
- full_o  out  1  occupancy_o == DEPTH
- overflow_cnt_o  out  16  saturating count of detections

Behaviour:
- Reset values (async, rst_ni low):
  - All entry valid bits 0; wr_ptr 0.
  - overflow_o 0, overflow_addr_o 0, occupancy_o 0, full_o 0, overflow_cnt_o 0.
- Storage: per entry {valid, base[ADDR_W], hwm[ADDR_W]}. Lookup is fully associative on base; at most one entry per base.
- Store handling (st_valid_i):
  - Offset = st_addr_i − st_base_i, unsigned ADDR_W arithmetic.
  - Store ignored if st_addr_i < st_base_i or offset > MAX_SPAN.
  - Hit: hwm ← max(hwm, st_addr_i) at the next edge.
  - Miss: allocate at wr_ptr with base ← st_base_i, hwm ← st_addr_i, valid ← 1; wr_ptr increments modulo DEPTH.
  - Allocating while full overwrites the oldest entry (FIFO replacement); occupancy is unchanged.
- Load check (ld_valid_i), combinational against current state plus same-cycle store forwarding:
  - Hit means a valid entry with base == ld_base_i, or an accepted same-cycle store with st_base_i == ld_base_i.
  - Effective hwm = max(stored hwm, forwarded st_addr_i).
  - Violation = hit and ld_addr_i ≥ ld_base_i and ld_addr_i > effective hwm.
  - Load miss or ld_addr_i < base: no violation.
- Result timing (latency 1 cycle):
  - overflow_o = violation registered; a one-cycle pulse per violating load.
  - overflow_addr_o loads ld_addr_i only on a violation and otherwise holds.
  - overflow_cnt_o increments on each violation and saturates at 16'hFFFF.
- Flush:
  - flush_i clears all valid bits and wr_ptr at the next edge; occupancy_o is 0 next cycle.
  - A same-cycle store is dropped.
  - A same-cycle load is still checked against pre-flush state.
  - overflow_cnt_o is not cleared by flush.
- Simultaneous store and load to different bases: both are processed independently in the same cycle.
- Reset mid-operation: all state returns to reset values immediately; no pending overflow survives.

Optional Feature:
- Macro: DLK_STICKY_EN.
- Defined: overflow_o is sticky. It sets on the first violation and stays 1 until flush_i or reset. overflow_addr_o keeps the first offending address; later violations do not update it but still increment overflow_cnt_o.
- Undefined: pulse behaviour as specified above.

Test Plan:
- Base 0x1000; SB to 0x1000..0x1007; then LB at 0x1005 -> overflow_o stays 0. Then LB at 0x1008 -> overflow_o=1 one cycle later, overflow_addr_o=0x1008, overflow_cnt_o=1.
- SB base 0x2000 addr 0x2000 with a same-cycle LB base 0x2000 addr 0x2000 -> no overflow (forwarding). Next cycle LB 0x2001 -> overflow.
- DEPTH+1 stores to distinct bases 0x100·k, k=0..8 -> full_o=1 after 8, occupancy_o=8. Then LB base 0x0 addr 0x10 -> no overflow (entry evicted).
- SB base 0x3000 addr 0x3000+MAX_SPAN+1 -> ignored, occupancy_o stays 0. SB addr 0x2FFF -> ignored.
- Fill 3 entries; assert flush_i together with a new SB -> occupancy_o=0 next cycle. LB on any old base -> no overflow.
- DLK_STICKY_EN: two violations at 0x1008 then 0x1010 -> overflow_o held 1, overflow_addr_o=0x1008, overflow_cnt_o=2. flush_i -> overflow_o=0.
